// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the breakout game controller and the game datapath / input logic.
// The slave side is the controller; the master side drives the game events.
interface breakout_game_ctrl_if;
    logic        frame_tick;
    logic        start_n;
    logic        brick_hit;
    logic        ball_lost;
    logic [5:0]  bricks_left;
    logic [2:0]  state;
    logic        run_enable;
    logic        serve;
    logic        clear_bricks;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        end_game;

    modport master (
        output frame_tick, start_n, brick_hit, ball_lost, bricks_left,
        input  state, run_enable, serve, clear_bricks, lives, score, end_game
    );

    modport slave (
        input  frame_tick, start_n, brick_hit, ball_lost, bricks_left,
        output state, run_enable, serve, clear_bricks, lives, score, end_game
    );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Game-flow controller for breakout: start/serve/play/lost/over/win sequencing,
// BCD score keeping and lives accounting. Every output comes straight from a register.
module breakout_game_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int LOST_FRAMES  = 90
) (
    input  logic                 clock,
    input  logic                 reset,
    breakout_game_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOST  = 3'd3,
        OVER  = 3'd4,
        WIN   = 3'd5
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [6:0] SERVE_LAST = 7'(SERVE_FRAMES - 1);
    localparam logic [6:0] LOST_LAST  = 7'(LOST_FRAMES - 1);

    state_t      state_q, state_d;
    logic [6:0]  frame_cnt_q, frame_cnt_d;
    logic        start_prev_q;
    logic [15:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic        serve_q, serve_d;
    logic        clear_q, clear_d;
    logic        run_q;
    logic        end_q;
    logic        press;

    // Four-digit BCD increment that sticks at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign press = start_prev_q & ~bus.start_n;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = bus.frame_tick ? frame_cnt_q + 7'd1 : frame_cnt_q;
        score_d     = score_q;
        lives_d     = lives_q;
        serve_d     = 1'b0;
        clear_d     = 1'b0;
        case (state_q)
            IDLE, OVER, WIN: begin
                if (press) begin
                    state_d = SERVE;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    serve_d = 1'b1;
                    clear_d = 1'b1;
                end
            end
            SERVE: begin
                if (bus.frame_tick && frame_cnt_q == SERVE_LAST) state_d = PLAY;
            end
            PLAY: begin
                if (bus.brick_hit) score_d = bcd_inc(score_q);
                // A miss outranks a clearing frame in the same cycle.
                if (bus.ball_lost) begin
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                    state_d = (lives_q <= 2'd1) ? OVER : LOST;
                end else if (bus.frame_tick && bus.bricks_left == 6'd0) begin
                    state_d = WIN;
                end
            end
            LOST: begin
                if (bus.frame_tick && frame_cnt_q == LOST_LAST) begin
                    state_d = SERVE;
                    serve_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) frame_cnt_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            start_prev_q <= 1'b1;
            score_q      <= '0;
            lives_q      <= LIVES_INIT;
            serve_q      <= 1'b0;
            clear_q      <= 1'b0;
            run_q        <= 1'b0;
            end_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            start_prev_q <= bus.start_n;
            score_q      <= score_d;
            lives_q      <= lives_d;
            serve_q      <= serve_d;
            clear_q      <= clear_d;
            run_q        <= (state_d == PLAY);
            end_q        <= (state_d == OVER) || (state_d == WIN);
        end
    end

    assign bus.state        = state_q;
    assign bus.run_enable   = run_q;
    assign bus.serve        = serve_q;
    assign bus.clear_bricks = clear_q;
    assign bus.lives        = lives_q;
    assign bus.score        = score_q;
    assign bus.end_game     = end_q;
endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboarded bench for breakout_game_ctrl: directed game scenarios plus randomized play,
// checked cycle by cycle against an integer-level reference model of the game rules.
module tb_breakout_game_ctrl;
    localparam int LIVES = 3;
    localparam int SF    = 2;
    localparam int LF    = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    breakout_game_ctrl_if bus ();

    breakout_game_ctrl #(
        .LIVES        (LIVES),
        .SERVE_FRAMES (SF),
        .LOST_FRAMES  (LF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]  state;
        logic        run;
        logic        serve;
        logic        clr;
        logic [1:0]  lives;
        logic [15:0] score;
        logic        eg;
    } out_t;

    out_t exp_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   clr_seen = 0;
    int   srv_seen = 0;

    // Reference model: game state as a small integer, score as a plain decimal number.
    int m_state, m_score, m_lives, m_frames;
    bit m_prev, m_serve, m_clr;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic out_t model_out();
        out_t o;
        o.state = 3'(m_state);
        o.run   = (m_state == 2);
        o.serve = m_serve;
        o.clr   = m_clr;
        o.lives = 2'(m_lives);
        o.score = to_bcd(m_score);
        o.eg    = (m_state == 4) || (m_state == 5);
        return o;
    endfunction

    function automatic out_t actual();
        out_t a;
        a.state = bus.state;
        a.run   = bus.run_enable;
        a.serve = bus.serve;
        a.clr   = bus.clear_bricks;
        a.lives = bus.lives;
        a.score = bus.score;
        a.eg    = bus.end_game;
        return a;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_score  = 0;
        m_lives  = LIVES;
        m_frames = 0;
        m_prev   = 1'b1;
        m_serve  = 1'b0;
        m_clr    = 1'b0;
    endtask

    task automatic model_step(input bit ft, input bit sn, input bit bh, input bit bl, input int bleft);
        bit press;
        press   = m_prev && !sn;
        m_prev  = sn;
        m_serve = 1'b0;
        m_clr   = 1'b0;
        case (m_state)
            0, 4, 5: if (press) begin
                m_state  = 1;
                m_score  = 0;
                m_lives  = LIVES;
                m_serve  = 1'b1;
                m_clr    = 1'b1;
                m_frames = 0;
            end
            1: if (ft) begin
                m_frames++;
                if (m_frames == SF) begin
                    m_state  = 2;
                    m_frames = 0;
                end
            end
            2: begin
                if (bh && m_score < 9999) m_score++;
                if (bl) begin
                    m_lives--;
                    m_state  = (m_lives == 0) ? 4 : 3;
                    m_frames = 0;
                end else if (ft && bleft == 0) begin
                    m_state = 5;
                end
            end
            3: if (ft) begin
                m_frames++;
                if (m_frames == LF) begin
                    m_state  = 1;
                    m_serve  = 1'b1;
                    m_frames = 0;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic cmp_vec(input string name, input out_t a, input out_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s @%0t: got st=%0d run=%0b srv=%0b clr=%0b lives=%0d score=%h eg=%0b, want st=%0d run=%0b srv=%0b clr=%0b lives=%0d score=%h eg=%0b",
                     name, $time, a.state, a.run, a.serve, a.clr, a.lives, a.score, a.eg,
                     e.state, e.run, e.serve, e.clr, e.lives, e.score, e.eg);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: whatever the stimulus side predicted for this edge is compared just after it.
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual();
                cmp_vec("cycle", a, e);
                if (a.clr)   clr_seen++;
                if (a.serve) srv_seen++;
            end
        end
    end

    task automatic cycle(input bit ft, input bit sn, input bit bh, input bit bl, input int bleft);
        @(negedge clock);
        bus.frame_tick  = ft;
        bus.start_n     = sn;
        bus.brick_hit   = bh;
        bus.ball_lost   = bl;
        bus.bricks_left = 6'(bleft);
        model_step(ft, sn, bh, bl, bleft);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b1, 1'b0, 1'b0, 20);
    endtask

    task automatic tick(input int n);
        repeat (n) cycle(1'b1, 1'b1, 1'b0, 1'b0, 20);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    task automatic new_game_to_play();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 20);
        tick(SF);
    endtask

    initial begin
        int c0, s0, guard;
        bit sn;
        bus.frame_tick  = 1'b0;
        bus.start_n     = 1'b1;
        bus.brick_hit   = 1'b0;
        bus.ball_lost   = 1'b0;
        bus.bricks_left = 6'd20;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        cmp_vec("reset_values", actual(), model_out());
        @(negedge clock);
        reset = 1'b0;
        idle(2);

        // Held start button: one press only
        c0 = clr_seen;
        s0 = srv_seen;
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0, 20);
        settle();
        check("start_clear_pulses", clr_seen - c0, 1);
        check("start_serve_pulses", srv_seen - s0, 1);
        check("start_state", bus.state, 1);
        check("start_lives", bus.lives, 3);
        check("start_score", bus.score, 16'h0000);

        // Serve countdown
        tick(1);
        idle(3);
        settle();
        check("serve_one_tick_state", bus.state, 1);
        tick(1);
        settle();
        check("serve_done_state", bus.state, 2);
        check("serve_done_run", bus.run_enable, 1);

        // Scoring and saturation
        repeat (10) cycle(1'b0, 1'b1, 1'b1, 1'b0, 20);
        settle();
        check("score_ten", bus.score, 16'h0010);
        repeat (9989) cycle(1'b0, 1'b1, 1'b1, 1'b0, 20);
        settle();
        check("score_9999", bus.score, 16'h9999);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 20);
        settle();
        check("score_saturate", bus.score, 16'h9999);

        // Three misses
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 20);
        settle();
        check("miss1_state", bus.state, 3);
        check("miss1_lives", bus.lives, 2);
        tick(LF);
        settle();
        check("miss1_serve_state", bus.state, 1);
        check("miss1_serve_pulse", bus.serve, 1);
        tick(SF);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 20);
        settle();
        check("miss2_state", bus.state, 3);
        check("miss2_lives", bus.lives, 1);
        tick(LF);
        tick(SF);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 20);
        settle();
        check("miss3_state", bus.state, 4);
        check("miss3_end_game", bus.end_game, 1);
        check("miss3_lives", bus.lives, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 20);
        settle();
        check("over_no_underflow", bus.lives, 0);

        // Win on an empty wall
        new_game_to_play();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
        settle();
        check("win_state", bus.state, 5);
        check("win_end_game", bus.end_game, 1);
        check("win_score", bus.score, 16'h0001);

        // Miss beats win, hit still scores
        new_game_to_play();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 20);
        tick(LF);
        tick(SF);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 20);
        tick(LF);
        tick(SF);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 0);
        settle();
        check("lose_over_win_state", bus.state, 4);
        check("lose_over_win_score", bus.score, 16'h0001);

        // Asynchronous reset in the middle of play
        new_game_to_play();
        idle(1);
        settle();
        @(posedge clock);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        cmp_vec("async_reset_before_edge", actual(), model_out());
        repeat (2) @(posedge clock);
        #2;
        cmp_vec("async_reset_held", actual(), model_out());
        @(negedge clock);
        reset = 1'b0;
        idle(5);
        settle();
        check("after_reset_idle", bus.state, 0);

        // Randomized play
        sn = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) sn = ~sn;
            cycle($urandom_range(0, 3) == 0, sn, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 24) == 0,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 32)));
        end
        settle();

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clock);
            #2;
            guard++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3: lives loaded at game start (1..3).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frames held in SERVE before play (>=1).
REQ-003 SHALL have parameter LOST_FRAMES, default 90: frames held in LOST after a miss (>=1).
REQ-004 SHALL have port clock  input  1: single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port frame_tick  input  1: one-cycle pulse at end of each frame (pixel 639,479).
REQ-007 SHALL have port start_n  input  1: start button, active-low, already synchronous.
REQ-008 SHALL have port brick_hit  input  1: one-cycle pulse per brick destroyed.
REQ-009 SHALL have port ball_lost  input  1: one-cycle pulse when ball reaches bottom border.
REQ-010 SHALL have port bricks_left  input  6: remaining bricks, 0..32.
REQ-011 SHALL have port state  output  3: IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4, WIN=5.
REQ-012 SHALL have port run_enable  output  1: ball/paddle motion permitted; high only in PLAY.
REQ-013 SHALL have port serve  output  1: one-cycle pulse; datapath recentres ball and paddle.
REQ-014 SHALL have port clear_bricks  output  1: one-cycle pulse; datapath restores all 32 bricks.
REQ-015 SHALL have port lives  output  2: lives remaining.
REQ-016 SHALL have port score  output  16: four BCD digits, [15:12] most significant.
REQ-017 SHALL have port end_game  output  1: high in OVER or WIN.

Function
REQ-018 All outputs SHALL be registered; no combinational input-to-output path.
REQ-019 Start press SHALL be the falling edge of start_n: previous sample 1, current sample 0; holding start_n low yields exactly one press.
REQ-020 IDLE, OVER or WIN + press -> next edge: state=SERVE, score=0, lives=LIVES, clear_bricks=1 and serve=1 for that one cycle.
REQ-021 A press in SERVE, PLAY or LOST SHALL be ignored.
REQ-022 SERVE SHALL count frame_tick pulses; on the edge sampling the SERVE_FRAMES-th tick since entry, state=PLAY.
REQ-023 In PLAY, each brick_hit SHALL add 1 to score as BCD with digit carry; 9999 saturates at 9999.
REQ-024 brick_hit outside PLAY SHALL be ignored.
REQ-025 In PLAY, ball_lost SHALL decrement lives next edge; result 0 -> OVER, else -> LOST.
REQ-026 In PLAY, frame_tick with bricks_left==0 and no ball_lost SHALL enter WIN.
REQ-027 Same cycle brick_hit + ball_lost: score increments and the loss is processed; loss takes priority over WIN.
REQ-028 ball_lost outside PLAY SHALL be ignored; lives never underflows below 0.
REQ-029 LOST SHALL count LOST_FRAMES frame_tick pulses, then enter SERVE with serve=1 for one cycle; bricks and score are unchanged.
REQ-030 Frame counter SHALL be 7 bits, cleared on every state entry, and advance only on frame_tick.
REQ-031 OVER and WIN SHALL hold score and lives until a press.
REQ-032 Undefined state encodings 6 and 7 SHALL return to IDLE next edge.

Reset
REQ-033 reset high SHALL immediately and asynchronously set state=IDLE, run_enable=0, serve=0, clear_bricks=0, end_game=0, score=0, lives=LIVES, frame counter=0 and previous start_n sample=1.
REQ-034 Reset asserted mid-game SHALL abandon the game; after release the block waits in IDLE for a press.

Verification
REQ-035 Bench SHALL cover reset then start_n low for 10 cycles -> one clear_bricks pulse and one serve pulse, state=1, lives=3, score=0000.
REQ-036 Bench SHALL cover SERVE_FRAMES=2: after start, two frame_ticks -> state=2, run_enable=1; one tick only -> state stays 1.
REQ-037 Bench SHALL cover in PLAY, 10 brick_hit pulses -> score=0x0010; from 9999, one more hit -> 9999.
REQ-038 Bench SHALL cover three ball_lost in PLAY with LOST_FRAMES=2 -> LOST and SERVE after the first two misses (lives 2, 1); the third miss gives state=4, end_game=1, lives=0.
REQ-039 Bench SHALL cover bricks_left=0 at frame_tick in PLAY -> state=5, end_game=1; the same cycle with ball_lost, lives=1 -> state=4.
REQ-040 Bench SHALL cover reset pulsed asynchronously during PLAY between clock edges -> outputs reach reset values before the next edge.
